// File: rtl/traffic_pkg.sv
// Shared signal codes and state encoding for the intersection controller.
package traffic_pkg;

    localparam logic [1:0] CAR_RED    = 2'd0;
    localparam logic [1:0] CAR_YELLOW = 2'd1;
    localparam logic [1:0] CAR_GREEN  = 2'd2;
    localparam logic [1:0] CAR_OFF    = 2'd3;

    localparam logic [1:0] PED_DONT_WALK = 2'd0;
    localparam logic [1:0] PED_WALK      = 2'd1;
    localparam logic [1:0] PED_FLASH     = 2'd2;

    typedef enum logic [2:0] {
        StGreen     = 3'd0,
        StYellow    = 3'd1,
        StRedClearA = 3'd2,
        StWalk      = 3'd3,
        StPedClear  = 3'd4,
        StRedClearB = 3'd5,
        StFlash     = 3'd6
    } state_e;

endpackage

// File: rtl/traffic_fsm_ped_request_sync.sv
// Pedestrian button synchronizer, rising-edge detect and pending-request latch.
module traffic_fsm_ped_request_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button,
    input  logic i_set_en,
    input  logic i_clr,
    output logic o_pending
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise = r_sync2 & ~r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Clear has priority so a request arriving on WALK entry is dropped.
            if (i_clr) begin
                r_pending <= 1'b0;
            end else if (w_rise && i_set_en) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/traffic_fsm.sv
// Intersection phase sequencer: green/yellow/all-red/walk phases plus night flash.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_W         = 16,
    parameter int unsigned GREEN_MIN_TICKS = 4,
    parameter int unsigned GREEN_MAX_TICKS = 10,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned RED_CLEAR_TICKS = 2,
    parameter int unsigned WALK_TICKS      = 5,
    parameter int unsigned PED_CLEAR_TICKS = 3,
    parameter int unsigned FLASH_TICKS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pedButton,
    input  logic       flashMode,
    output logic [1:0] fsmCarControl,
    output logic [1:0] fsmPedControl,
    output logic       pedWaiting,
    output logic [2:0] stateDebug
);

    state_e             r_state;
    state_e             w_state_d;
    logic [TIMER_W-1:0] r_cnt;
    logic [TIMER_W-1:0] w_cnt_d;
    logic               r_flash_ph;
    logic               w_flash_ph_d;
    logic               w_flash_toggle;
    logic [1:0]         r_car;
    logic [1:0]         r_ped;
    logic [1:0]         w_car_d;
    logic [1:0]         w_ped_d;
    logic               w_ped_set_en;
    logic               w_ped_clr;
    logic               w_ped_waiting;

    function automatic logic last_tick(input logic [TIMER_W-1:0] cnt, input int unsigned ticks);
        return cnt == TIMER_W'(ticks - 1);
    endfunction

    always_comb begin
        w_state_d      = r_state;
        w_flash_toggle = 1'b0;
        case (r_state)
            StGreen: begin
                if (((r_cnt >= TIMER_W'(GREEN_MIN_TICKS - 1)) && (w_ped_waiting || flashMode))
                    || last_tick(r_cnt, GREEN_MAX_TICKS)) begin
                    w_state_d = StYellow;
                end
            end
            StYellow: if (last_tick(r_cnt, YELLOW_TICKS)) w_state_d = StRedClearA;
            StRedClearA: begin
                if (last_tick(r_cnt, RED_CLEAR_TICKS)) begin
                    if (flashMode)          w_state_d = StFlash;
                    else if (w_ped_waiting) w_state_d = StWalk;
                    else                    w_state_d = StGreen;
                end
            end
            StWalk:     if (last_tick(r_cnt, WALK_TICKS)) w_state_d = StPedClear;
            StPedClear: if (last_tick(r_cnt, PED_CLEAR_TICKS)) w_state_d = StRedClearB;
            StRedClearB: begin
                if (last_tick(r_cnt, RED_CLEAR_TICKS)) begin
                    w_state_d = flashMode ? StFlash : StGreen;
                end
            end
            StFlash: begin
                if (last_tick(r_cnt, FLASH_TICKS)) begin
                    if (!flashMode) w_state_d = StRedClearA;
                    else            w_flash_toggle = 1'b1;
                end
            end
            default: w_state_d = StRedClearA;
        endcase

        // In FLASH the counter restarts at every half-period boundary.
        if ((w_state_d != r_state) || w_flash_toggle) w_cnt_d = '0;
        else                                          w_cnt_d = r_cnt + 1'b1;

        if ((w_state_d != StFlash) || (r_state != StFlash)) w_flash_ph_d = 1'b0;
        else if (w_flash_toggle)                           w_flash_ph_d = ~r_flash_ph;
        else                                               w_flash_ph_d = r_flash_ph;

        w_car_d = CAR_RED;
        w_ped_d = PED_DONT_WALK;
        case (w_state_d)
            StGreen:    w_car_d = CAR_GREEN;
            StYellow:   w_car_d = CAR_YELLOW;
            StWalk:     w_ped_d = PED_WALK;
            StPedClear: w_ped_d = PED_FLASH;
            StFlash:    w_car_d = w_flash_ph_d ? CAR_OFF : CAR_YELLOW;
            default:    w_car_d = CAR_RED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StRedClearA;
            r_cnt      <= '0;
            r_flash_ph <= 1'b0;
            r_car      <= CAR_RED;
            r_ped      <= PED_DONT_WALK;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_flash_ph <= w_flash_ph_d;
            r_car      <= w_car_d;
            r_ped      <= w_ped_d;
        end
    end

    assign w_ped_set_en = (r_state != StWalk) && (r_state != StFlash);
    assign w_ped_clr    = (w_state_d == StWalk) && (r_state != StWalk);

    traffic_fsm_ped_request_sync u_ped_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_button (pedButton),
        .i_set_en (w_ped_set_en),
        .i_clr    (w_ped_clr),
        .o_pending(w_ped_waiting)
    );

    assign fsmCarControl = r_car;
    assign fsmPedControl = r_ped;
    assign pedWaiting    = w_ped_waiting;
    assign stateDebug    = r_state;

endmodule
